// File: rtl/isdu_ctrl.sv
// Control FSM for a small LC-3 style datapath: fetch, decode and execute
// sequencing with a parameterised memory wait, decoding registered state and IR only.
module isdu_ctrl #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset_al,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic        MIO_EN,
    output logic        Mem_OE_N,
    output logic        Mem_WE_N,
    output logic [4:0]  state_dbg
);

    typedef enum logic [4:0] {
        S_HALTED, S_F1, S_F2, S_F3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKE, S_JMP,
        S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3, S_PAUSE1, S_PAUSE2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] wait_cnt;
    logic       wait_done;
    logic       in_wait;
    logic       ir_unused;

    assign wait_done = (wait_cnt == 3'(MEM_WAIT));
    assign in_wait   = (state == S_F2) || (state == S_LDR2) || (state == S_STR3);
    assign state_dbg = state;
    assign ir_unused = ^{IR[11:6], IR[4:0]};

    // The counter restarts on every state change, so each memory phase begins at zero.
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            state    <= S_HALTED;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (in_wait) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        MIO_EN     = 1'b0;
        Mem_OE_N   = 1'b1;
        Mem_WE_N   = 1'b1;

        case (state)
            S_HALTED: if (Run) state_next = S_F1;
            S_F1: begin
                GatePC     = 1'b1;
                LD_MAR     = 1'b1;
                LD_PC      = 1'b1;
                state_next = S_F2;
            end
            S_F2, S_LDR2: begin
                Mem_OE_N = 1'b0;
                if (wait_done) begin
                    LD_MDR     = 1'b1;
                    state_next = (state == S_F2) ? S_F3 : S_LDR3;
                end
            end
            S_F3: begin
                GateMDR    = 1'b1;
                LD_IR      = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                LD_BEN = 1'b1;
                case (IR[15:12])
                    4'b0001: state_next = S_ADD;
                    4'b0101: state_next = S_AND;
                    4'b1001: state_next = S_NOT;
                    4'b0000: state_next = S_BR;
                    4'b1100: state_next = S_JMP;
                    4'b0100: state_next = S_JSR1;
                    4'b0110: state_next = S_LDR1;
                    4'b0111: state_next = S_STR1;
                    4'b1101: state_next = S_PAUSE1;
                    default: state_next = S_F1;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                SR1MUX     = 1'b1;
                SR2MUX     = IR[5];
                ALUK       = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b10;
                GateALU    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                state_next = S_F1;
            end
            S_BR: state_next = BEN ? S_BR_TAKE : S_F1;
            S_BR_TAKE: begin
                ADDR2MUX   = 2'b10;
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                state_next = S_F1;
            end
            S_JMP: begin
                SR1MUX     = 1'b1;
                SR2MUX     = IR[5];
                ALUK       = 2'b11;
                GateALU    = 1'b1;
                PCMUX      = 2'b01;
                LD_PC      = 1'b1;
                state_next = S_F1;
            end
            S_JSR1: begin
                GatePC     = 1'b1;
                DRMUX      = 1'b1;
                LD_REG     = 1'b1;
                state_next = S_JSR2;
            end
            S_JSR2: begin
                ADDR2MUX   = 2'b11;
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                state_next = S_F1;
            end
            S_LDR1, S_STR1: begin
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                SR1MUX     = 1'b1;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_next = (state == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR3: begin
                GateMDR    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                state_next = S_F1;
            end
            S_STR2: begin
                SR2MUX     = IR[5];
                ALUK       = 2'b11;
                GateALU    = 1'b1;
                MIO_EN     = 1'b1;
                LD_MDR     = 1'b1;
                state_next = S_STR3;
            end
            S_STR3: begin
                Mem_WE_N = 1'b0;
                if (wait_done) state_next = S_F1;
            end
            S_PAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) state_next = S_PAUSE2;
            end
            S_PAUSE2: if (!Continue) state_next = S_F1;
            default: state_next = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_isdu_ctrl.sv
// Bench for isdu_ctrl: per-instruction timeline model feeding an expected queue,
// checked every cycle, plus literal spot checks on fetch, ADD and async reset.
module tb_isdu_ctrl;

    localparam int W = 2;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       drmux, sr1mux, sr2mux, addr1mux, mio_en, mem_oe_n, mem_we_n;
    } ctl_t;

    localparam ctl_t IDLE = 25'h3;

    logic        Clk = 1'b0;
    logic        Reset_al, Run, Continue, BEN;
    logic [15:0] IR;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE_N, Mem_WE_N;
    logic [4:0]  state_dbg;

    ctl_t got;
    ctl_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    isdu_ctrl #(.MEM_WAIT(W)) dut (
        .Clk(Clk), .Reset_al(Reset_al), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC), .GateMDR(GateMDR),
        .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
        .ALUK(ALUK), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .MIO_EN(MIO_EN), .Mem_OE_N(Mem_OE_N), .Mem_WE_N(Mem_WE_N), .state_dbg(state_dbg)
    );

    assign got = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE_N, Mem_WE_N};

    always #5 Clk = ~Clk;

    // Compare process: one expected vector per cycle, plus bus/strobe invariants.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            ctl_t e;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cycle_ctl: got %h expected %h at %0t", got, e, $time);
            end
        end
        checks++;
        if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1) begin
            errors++;
            $display("FAIL gate_onehot: got %b expected at most one high at %0t",
                     {GatePC, GateMDR, GateALU, GateMARMUX}, $time);
        end
        checks++;
        if (!Mem_OE_N && !Mem_WE_N) begin
            errors++;
            $display("FAIL strobe_excl: got oe_n=0 we_n=0 expected not both low at %0t", $time);
        end
    end

    task automatic lit(input string nm, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, g, e, $time);
        end
    endtask

    function automatic logic r();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cyc(input ctl_t e, input logic run_v, input logic cont_v, input logic ben_v);
        Run      = run_v;
        Continue = cont_v;
        BEN      = ben_v;
        exp_q.push_back(e);
        step();
    endtask

    function automatic ctl_t rd(input logic last);
        ctl_t c;
        c = IDLE;
        c.mem_oe_n = 1'b0;
        c.ld_mdr   = last;
        return c;
    endfunction

    // Asynchronous reset in the middle of a memory phase, then a restart from HALTED.
    task automatic do_abort(input string nm, input logic [1:0] pre);
        lit({nm, "_pre"}, {30'd0, Mem_OE_N, Mem_WE_N}, {30'd0, pre});
        exp_q.push_back(IDLE);
        #1 Reset_al = 1'b0;
        #1 lit({nm, "_async"}, 32'(got), 32'(IDLE));
        @(posedge Clk);
        #1 Reset_al = 1'b1;
        cyc(IDLE, 1'b0, r(), r());
        cyc(IDLE, 1'b0, r(), r());
        cyc(IDLE, 1'b1, r(), r());
    endtask

    // Timeline of one instruction starting at its F1 cycle; abort 1 = reset in F2
    // second cycle, abort 2 = reset in first STR3 cycle.
    task automatic exec_instr(input logic [15:0] ir, input int ben_sel, input int p1,
                              input int hold, input int abort);
        ctl_t c;
        logic b;
        IR = ir;
        c = IDLE; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1;
        cyc(c, r(), r(), r());
        for (int i = 0; i <= W; i++) begin
            if (abort == 1 && i == 1) begin
                do_abort("f2_reset", 2'b01);
                return;
            end
            cyc(rd(i == W), r(), r(), r());
        end
        c = IDLE; c.gate_mdr = 1; c.ld_ir = 1;
        cyc(c, r(), r(), r());
        c = IDLE; c.ld_ben = 1;
        cyc(c, r(), r(), r());
        c = IDLE;
        case (ir[15:12])
            4'h1, 4'h5, 4'h9: begin
                c.sr1mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr2mux = ir[5];
                c.aluk = (ir[15:12] == 4'h1) ? 2'd0 : (ir[15:12] == 4'h5) ? 2'd1 : 2'd2;
                cyc(c, r(), r(), r());
            end
            4'h0: begin
                b = (ben_sel < 0) ? r() : ben_sel[0];
                cyc(IDLE, r(), r(), b);
                if (b) begin
                    c.addr2mux = 2'd2; c.pcmux = 2'd2; c.ld_pc = 1;
                    cyc(c, r(), r(), r());
                end
            end
            4'hC: begin
                c.sr1mux = 1; c.aluk = 2'd3; c.gate_alu = 1; c.pcmux = 2'd1; c.ld_pc = 1;
                c.sr2mux = ir[5];
                cyc(c, r(), r(), r());
            end
            4'h4: begin
                c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1;
                cyc(c, r(), r(), r());
                c = IDLE; c.addr2mux = 2'd3; c.pcmux = 2'd2; c.ld_pc = 1;
                cyc(c, r(), r(), r());
            end
            4'h6, 4'h7: begin
                c.addr1mux = 1; c.addr2mux = 2'd1; c.sr1mux = 1; c.gate_marmux = 1; c.ld_mar = 1;
                cyc(c, r(), r(), r());
                if (ir[15:12] == 4'h6) begin
                    for (int i = 0; i <= W; i++) cyc(rd(i == W), r(), r(), r());
                    c = IDLE; c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1;
                    cyc(c, r(), r(), r());
                end else begin
                    c = IDLE; c.aluk = 2'd3; c.gate_alu = 1; c.mio_en = 1; c.ld_mdr = 1;
                    c.sr2mux = ir[5];
                    cyc(c, r(), r(), r());
                    for (int i = 0; i <= W; i++) begin
                        if (abort == 2 && i == 0) begin
                            do_abort("str3_reset", 2'b10);
                            return;
                        end
                        c = IDLE; c.mem_we_n = 0;
                        cyc(c, r(), r(), r());
                    end
                end
            end
            4'hD: begin
                c.ld_led = 1;
                for (int k = 0; k < p1; k++) cyc(c, r(), 1'b0, r());
                cyc(c, r(), 1'b1, r());
                for (int k = 0; k < hold; k++) cyc(IDLE, r(), 1'b1, r());
                cyc(IDLE, r(), 1'b0, r());
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [3:0] op;
        int         ab;
        Reset_al = 1'b0;
        Run      = 1'b0;
        Continue = 1'b0;
        BEN      = 1'b0;
        IR       = 16'h1283;
        #2 lit("reset_idle", 32'(got), 32'(IDLE));
        step();
        step();
        Reset_al = 1'b1;
        lit("halted_idle", 32'(got), 32'(IDLE));
        step();
        lit("halted_hold", 32'(got), 32'(IDLE));
        Run = 1'b1;
        step();
        Run = 1'b0;
        lit("f1", {GatePC, LD_MAR, LD_PC, PCMUX}, 32'b11100);
        step();
        lit("f2_c0", {Mem_OE_N, MIO_EN, LD_MDR}, 32'b000);
        step();
        lit("f2_c1", {Mem_OE_N, MIO_EN, LD_MDR}, 32'b000);
        step();
        lit("f2_c2", {Mem_OE_N, MIO_EN, LD_MDR}, 32'b001);
        step();
        lit("f3", {GateMDR, LD_IR, Mem_OE_N}, 32'b111);
        step();
        lit("decode", {LD_BEN, LD_IR}, 32'b10);
        step();
        lit("add_exec", {GateALU, ALUK, SR2MUX, LD_REG, LD_CC, DRMUX, SR1MUX}, 32'b10001101);
        step();
        lit("add_to_f1", {GatePC, LD_PC, GateALU}, 32'b110);

        exec_instr(16'h0E05, 1, 0, 0, 0);
        exec_instr(16'h0E05, 0, 0, 0, 0);
        exec_instr(16'h7442, -1, 0, 0, 0);
        exec_instr(16'hD0FF, -1, 0, 4, 0);
        exec_instr(16'h12A3, -1, 0, 0, 0);
        exec_instr(16'h1283, -1, 0, 0, 1);
        exec_instr(16'h7442, -1, 0, 0, 2);

        for (int n = 0; n < 160; n++) begin
            op = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 24) == 0) ? 1 : 0;
            if (op == 4'h7 && $urandom_range(0, 5) == 0) ab = 2;
            exec_instr({op, 12'($urandom)}, -1, $urandom_range(0, 3), $urandom_range(0, 4), ab);
        end

        for (int t = 0; t < 5 && exp_q.size() > 0; t++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
